// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus configuration front end.
// Holds the default geometry, the configuration FSM state codes and the
// per-master transaction descriptor layout.
package bus_pkg;

  localparam int unsigned N_MASTERS = 2;
  localparam int unsigned N_SLAVES  = 3;
  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BURST_W   = 4;
  localparam int unsigned SW_W      = 12;
  localparam int unsigned SLV_W     = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  // Codes are visible on the LEDs, so they are fixed explicitly.
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StMsel = 3'd1,
    StSsel = 3'd2,
    StAsel = 3'd3,
    StDsel = 3'd4,
    StBsel = 3'd5,
    StDone = 3'd6
  } cfg_state_t;

  typedef struct packed {
    logic [SLV_W-1:0]   slave;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
    logic [BURST_W-1:0] burst;
  } cfg_desc_t;

  // Modulo-n increment used by the master and slave selectors.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/bus_config_ctrl_if.sv
// Operator panel / master-facing bundle of the configuration front end.
//   mode_switch, btn_next_n, btn_inc_n, switch_array : panel inputs (raw, async)
//   cfg_slave/addr/data/burst : committed descriptor per master
//   cfg_valid  : per-master descriptor present
//   cfg_update : single-cycle commit strobe
//   cfg_state  : FSM state code for LEDs
// modport master: panel/consumer side; modport slave: the controller.
interface bus_config_ctrl_if #(
  parameter int unsigned N_MASTERS = bus_pkg::N_MASTERS,
  parameter int unsigned N_SLAVES  = bus_pkg::N_SLAVES,
  parameter int unsigned ADDR_W    = bus_pkg::ADDR_W,
  parameter int unsigned DATA_W    = bus_pkg::DATA_W,
  parameter int unsigned BURST_W   = bus_pkg::BURST_W
) ();

  localparam int unsigned SlvW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  logic                              mode_switch;
  logic                              btn_next_n;
  logic                              btn_inc_n;
  logic [11:0]                       switch_array;
  logic [N_MASTERS-1:0][SlvW-1:0]    cfg_slave;
  logic [N_MASTERS-1:0][ADDR_W-1:0]  cfg_addr;
  logic [N_MASTERS-1:0][DATA_W-1:0]  cfg_data;
  logic [N_MASTERS-1:0][BURST_W-1:0] cfg_burst;
  logic [N_MASTERS-1:0]              cfg_valid;
  logic                              cfg_update;
  logic [2:0]                        cfg_state;

  modport master (
    output mode_switch, btn_next_n, btn_inc_n, switch_array,
    input  cfg_slave, cfg_addr, cfg_data, cfg_burst, cfg_valid, cfg_update, cfg_state
  );

  modport slave (
    input  mode_switch, btn_next_n, btn_inc_n, switch_array,
    output cfg_slave, cfg_addr, cfg_data, cfg_burst, cfg_valid, cfg_update, cfg_state
  );

endinterface

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer followed by a registered falling-edge detector.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   d_i    : asynchronous level input
//   sync_o : synchronized level
//   fall_o : one-cycle pulse per 1->0 transition of the synchronized level
// All flops reset to RstVal (the released level) so reset never fakes an edge.
module btn_edge_sync #(
  parameter logic RstVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic sync_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       last_q;
  logic       fall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {2{RstVal}};
      last_q <= RstVal;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], d_i};
      last_q <= sync_q[1];
      // Registered so the pulse is a clean flop output; a held level stays low
      // in both sync_q[1] and last_q and yields no further pulses.
      fall_q <= last_q & ~sync_q[1];
    end
  end

  assign sync_o = sync_q[1];
  assign fall_o = fall_q;

endmodule

// File: rtl/bus_config_ctrl.sv
// Configuration-mode front end. Steps the operator through master, slave,
// address, data and burst selection and commits a descriptor per master.
//   clock : rising-edge clock
//   rst   : synchronous active-high reset
//   bus   : panel inputs and committed descriptor outputs (slave modport)
// All outputs come straight from flops.
module bus_config_ctrl #(
  parameter int unsigned N_MASTERS = bus_pkg::N_MASTERS,
  parameter int unsigned N_SLAVES  = bus_pkg::N_SLAVES,
  parameter int unsigned ADDR_W    = bus_pkg::ADDR_W,
  parameter int unsigned DATA_W    = bus_pkg::DATA_W,
  parameter int unsigned BURST_W   = bus_pkg::BURST_W
) (
  input  logic             clock,
  input  logic             rst,
  bus_config_ctrl_if.slave bus
);
  import bus_pkg::*;

  localparam int unsigned MstW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  logic next_evt;
  logic inc_evt;
  logic mode_sync;
  logic unused_next_sync;
  logic unused_inc_sync;
  logic unused_mode_fall;

  btn_edge_sync #(
    .RstVal (1'b1)
  ) u_next_sync (
    .clk_i  (clock),
    .rst_i  (rst),
    .d_i    (bus.btn_next_n),
    .sync_o (unused_next_sync),
    .fall_o (next_evt)
  );

  btn_edge_sync #(
    .RstVal (1'b1)
  ) u_inc_sync (
    .clk_i  (clock),
    .rst_i  (rst),
    .d_i    (bus.btn_inc_n),
    .sync_o (unused_inc_sync),
    .fall_o (inc_evt)
  );

  // Mode only needs the level; its edge output is left unused.
  btn_edge_sync #(
    .RstVal (1'b0)
  ) u_mode_sync (
    .clk_i  (clock),
    .rst_i  (rst),
    .d_i    (bus.mode_switch),
    .sync_o (mode_sync),
    .fall_o (unused_mode_fall)
  );

  cfg_state_t           state_q;
  logic [MstW-1:0]      mst_q;
  cfg_desc_t            work_q;
  cfg_desc_t            desc_q [N_MASTERS];
  logic [N_MASTERS-1:0] valid_q;
  logic                 update_q;

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q  <= StIdle;
      mst_q    <= '0;
      work_q   <= '0;
      valid_q  <= '0;
      update_q <= 1'b0;
      for (int m = 0; m < N_MASTERS; m++) begin
        desc_q[m] <= '0;
      end
    end else begin
      update_q <= 1'b0;
      if (state_q != StIdle && mode_sync) begin
        // Leaving configuration mode abandons the sequence without a commit.
        state_q <= StIdle;
        work_q  <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (next_evt && !mode_sync) begin
              state_q <= StMsel;
              mst_q   <= '0;
              work_q  <= '0;
            end
          end
          StMsel: begin
            // next_evt takes priority; a coincident inc_evt is dropped.
            if (next_evt) begin
              state_q      <= StSsel;
              work_q.slave <= valid_q[mst_q] ? desc_q[mst_q].slave : '0;
            end else if (inc_evt) begin
              mst_q <= MstW'(wrap_inc(32'(mst_q), N_MASTERS));
            end
          end
          StSsel: begin
            if (next_evt) begin
              state_q <= StAsel;
            end else if (inc_evt) begin
              work_q.slave <= SLV_W'(wrap_inc(32'(work_q.slave), N_SLAVES));
            end
          end
          StAsel: begin
            if (next_evt) begin
              state_q     <= StDsel;
              work_q.addr <= bus.switch_array[ADDR_W-1:0];
            end
          end
          StDsel: begin
            if (next_evt) begin
              state_q     <= StBsel;
              work_q.data <= bus.switch_array[DATA_W-1:0];
            end
          end
          StBsel: begin
            if (next_evt) begin
              state_q      <= StDone;
              work_q.burst <= bus.switch_array[BURST_W-1:0];
            end
          end
          StDone: begin
            if (next_evt) begin
              state_q        <= StIdle;
              desc_q[mst_q]  <= work_q;
              valid_q[mst_q] <= 1'b1;
              update_q       <= 1'b1;
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  for (genvar m = 0; m < N_MASTERS; m++) begin : g_out
    assign bus.cfg_slave[m] = desc_q[m].slave;
    assign bus.cfg_addr[m]  = desc_q[m].addr;
    assign bus.cfg_data[m]  = desc_q[m].data;
    assign bus.cfg_burst[m] = desc_q[m].burst;
  end

  assign bus.cfg_valid  = valid_q;
  assign bus.cfg_update = update_q;
  assign bus.cfg_state  = state_q;

endmodule

// File: tb/tb_bus_config_ctrl.sv
// Self-checking bench for bus_config_ctrl with a slot-level reference model.
module tb_bus_config_ctrl;
  import bus_pkg::*;

  logic clock = 1'b0;
  logic rst   = 1'b1;

  bus_config_ctrl_if bus ();

  bus_config_ctrl dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp   = 0;
  int n_fail  = 0;
  int upd_cnt = 0;
  int exp_upd = 0;

  // Reference model: what each master slot should hold.
  logic               m_valid [N_MASTERS];
  logic [SLV_W-1:0]   m_slave [N_MASTERS];
  logic [ADDR_W-1:0]  m_addr  [N_MASTERS];
  logic [DATA_W-1:0]  m_data  [N_MASTERS];
  logic [BURST_W-1:0] m_burst [N_MASTERS];

  always @(posedge clock) if (bus.cfg_update === 1'b1) upd_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic model_reset();
    for (int m = 0; m < N_MASTERS; m++) begin
      m_valid[m] = 1'b0; m_slave[m] = '0; m_addr[m] = '0; m_data[m] = '0; m_burst[m] = '0;
    end
  endtask

  task automatic press(input logic nxt, input logic inc, input int hold);
    @(negedge clock);
    if (nxt) bus.btn_next_n = 1'b0;
    if (inc) bus.btn_inc_n = 1'b0;
    repeat (hold) @(negedge clock);
    bus.btn_next_n = 1'b1;
    bus.btn_inc_n  = 1'b1;
    repeat (5) @(negedge clock);
  endtask

  task automatic abort_seq();
    @(negedge clock);
    bus.mode_switch = 1'b1;
    repeat (5) @(negedge clock);
    bus.mode_switch = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  // Full operator sequence; the model is updated only if the commit happens.
  task automatic do_config(input int mi, input int si, input logic [11:0] a,
                           input logic [11:0] d, input logic [11:0] b, input int abort_at);
    int m;
    int entry;
    m     = mi % N_MASTERS;
    entry = m_valid[m] ? int'(m_slave[m]) : 0;
    press(1'b1, 1'b0, 3);
    if (abort_at == 1) begin abort_seq(); return; end
    repeat (mi) press(1'b0, 1'b1, 3);
    press(1'b1, 1'b0, 3);
    if (abort_at == 2) begin abort_seq(); return; end
    repeat (si) press(1'b0, 1'b1, 3);
    press(1'b1, 1'b0, 3);
    if (abort_at == 3) begin abort_seq(); return; end
    bus.switch_array = a; press(1'b1, 1'b0, 3); bus.switch_array = 12'($urandom);
    if (abort_at == 4) begin abort_seq(); return; end
    bus.switch_array = d; press(1'b1, 1'b0, 3); bus.switch_array = 12'($urandom);
    if (abort_at == 5) begin abort_seq(); return; end
    bus.switch_array = b; press(1'b1, 1'b0, 3); bus.switch_array = 12'($urandom);
    if (abort_at == 6) begin abort_seq(); return; end
    press(1'b1, 1'b0, 3);
    m_valid[m] = 1'b1;
    m_slave[m] = SLV_W'((entry + si) % N_SLAVES);
    m_addr[m]  = a[ADDR_W-1:0];
    m_data[m]  = d[DATA_W-1:0];
    m_burst[m] = b[BURST_W-1:0];
    exp_upd++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_cmp++;
    if (bus.cfg_state !== 3'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d want 0", bus.cfg_state);
    end
    n_cmp++;
    if (bus.cfg_valid !== '0 || bus.cfg_update !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: valid=%b update=%b want 0", bus.cfg_valid,
                         bus.cfg_update);
    end
    for (int m = 0; m < N_MASTERS; m++) begin
      n_cmp++;
      if ({bus.cfg_slave[m], bus.cfg_addr[m], bus.cfg_data[m], bus.cfg_burst[m]} !== '0) begin
        n_fail++; $display("FAIL reset_desc[%0d]: got %h want 0", m,
                           {bus.cfg_slave[m], bus.cfg_addr[m], bus.cfg_data[m], bus.cfg_burst[m]});
      end
    end
    rst = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_single();
    int          exp_st [6] = '{1, 2, 3, 4, 5, 6};
    logic [11:0] sw [6] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'd12, 12'd35, 12'd0};
    logic        seen;
    int          hi_cnt;
    logic [2:0]  st_at;
    logic [26:0] dsc_at;
    for (int i = 0; i < 6; i++) begin
      bus.switch_array = sw[i];
      press(1'b1, 1'b0, 3);
      bus.switch_array = 12'hA5A;
      n_cmp++;
      if (bus.cfg_state !== 3'(exp_st[i])) begin
        n_fail++; $display("FAIL single_step%0d: state %0d want %0d", i, bus.cfg_state, exp_st[i]);
      end
    end
    seen = 1'b0; hi_cnt = 0; st_at = '1; dsc_at = '0;
    @(negedge clock);
    bus.btn_next_n = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      if (k == 2) bus.btn_next_n = 1'b1;
      if (bus.cfg_update === 1'b1) begin
        hi_cnt++;
        if (!seen) begin
          seen   = 1'b1;
          st_at  = bus.cfg_state;
          dsc_at = {bus.cfg_valid[0], bus.cfg_slave[0], bus.cfg_addr[0], bus.cfg_data[0],
                    bus.cfg_burst[0]};
        end
      end
    end
    m_valid[0] = 1'b1; m_slave[0] = '0; m_addr[0] = 12'd12; m_data[0] = 8'd35; m_burst[0] = '0;
    exp_upd++;
    n_cmp++;
    if (hi_cnt != 1) begin
      n_fail++; $display("FAIL single_update_pulse: %0d cycles high want 1", hi_cnt);
    end
    n_cmp++;
    if (st_at !== 3'd0) begin
      n_fail++; $display("FAIL single_commit_state: state %0d want 0", st_at);
    end
    n_cmp++;
    if (dsc_at !== {1'b1, 2'd0, 12'd12, 8'd35, 4'd0}) begin
      n_fail++; $display("FAIL single_commit_desc: got %h want %h", dsc_at,
                         {1'b1, 2'd0, 12'd12, 8'd35, 4'd0});
    end
    n_cmp++;
    if (bus.cfg_valid[1] !== 1'b0 || upd_cnt != exp_upd) begin
      n_fail++; $display("FAIL single_other: valid1=%b upd=%0d want 0/%0d", bus.cfg_valid[1],
                         upd_cnt, exp_upd);
    end
  endtask

  task automatic test_burst();
    do_config(1, 1, 12'd12, 12'd35, 12'd5, -1);
    n_cmp++;
    if ({bus.cfg_valid[1], bus.cfg_slave[1], bus.cfg_addr[1], bus.cfg_data[1], bus.cfg_burst[1]}
        !== {1'b1, 2'd1, 12'd12, 8'd35, 4'd5}) begin
      n_fail++; $display("FAIL burst_m1: got %h want %h", {bus.cfg_valid[1], bus.cfg_slave[1],
                         bus.cfg_addr[1], bus.cfg_data[1], bus.cfg_burst[1]},
                         {1'b1, 2'd1, 12'd12, 8'd35, 4'd5});
    end
    n_cmp++;
    if ({bus.cfg_valid[0], bus.cfg_slave[0], bus.cfg_addr[0], bus.cfg_data[0], bus.cfg_burst[0]}
        !== {m_valid[0], m_slave[0], m_addr[0], m_data[0], m_burst[0]}) begin
      n_fail++; $display("FAIL burst_m0_kept: got %h want %h", {bus.cfg_valid[0],
                         bus.cfg_slave[0], bus.cfg_addr[0], bus.cfg_data[0], bus.cfg_burst[0]},
                         {m_valid[0], m_slave[0], m_addr[0], m_data[0], m_burst[0]});
    end
  endtask

  task automatic test_wrap();
    int entry;
    entry = int'(m_slave[1]);
    press(1'b1, 1'b0, 3);
    press(1'b0, 1'b1, 3);
    press(1'b1, 1'b0, 3);
    repeat (N_SLAVES) press(1'b0, 1'b1, 3);
    press(1'b1, 1'b0, 3);
    n_cmp++;
    if (bus.cfg_state !== 3'd3) begin
      n_fail++; $display("FAIL wrap_asel: state %0d want 3", bus.cfg_state);
    end
    press(1'b0, 1'b1, 3);
    n_cmp++;
    if (bus.cfg_state !== 3'd3) begin
      n_fail++; $display("FAIL wrap_inc_ignored: state %0d want 3", bus.cfg_state);
    end
    bus.switch_array = 12'h5A5; press(1'b1, 1'b0, 3);
    bus.switch_array = 12'h93C; press(1'b1, 1'b0, 3);
    bus.switch_array = 12'h0F7; press(1'b1, 1'b0, 3);
    press(1'b1, 1'b0, 3);
    m_slave[1] = SLV_W'(entry); m_addr[1] = 12'h5A5; m_data[1] = 8'h3C; m_burst[1] = 4'h7;
    exp_upd++;
    for (int m = 0; m < N_MASTERS; m++) begin
      n_cmp++;
      if ({bus.cfg_valid[m], bus.cfg_slave[m], bus.cfg_addr[m], bus.cfg_data[m], bus.cfg_burst[m]}
          !== {m_valid[m], m_slave[m], m_addr[m], m_data[m], m_burst[m]}) begin
        n_fail++; $display("FAIL wrap_desc[%0d]: got %h want %h", m, {bus.cfg_valid[m],
                           bus.cfg_slave[m], bus.cfg_addr[m], bus.cfg_data[m], bus.cfg_burst[m]},
                           {m_valid[m], m_slave[m], m_addr[m], m_data[m], m_burst[m]});
      end
    end
  endtask

  task automatic test_abort();
    logic got;
    repeat (3) press(1'b1, 1'b0, 3);
    bus.switch_array = 12'hFFF; press(1'b1, 1'b0, 3);
    n_cmp++;
    if (bus.cfg_state !== 3'd4) begin
      n_fail++; $display("FAIL abort_dsel: state %0d want 4", bus.cfg_state);
    end
    @(negedge clock);
    bus.mode_switch = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (bus.cfg_state === 3'd0) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_fail++; $display("FAIL abort_idle: state %0d want 0 within 3 cycles", bus.cfg_state);
    end
    press(1'b1, 1'b0, 3);
    n_cmp++;
    if (bus.cfg_state !== 3'd0) begin
      n_fail++; $display("FAIL abort_opmode_next: state %0d want 0", bus.cfg_state);
    end
    bus.mode_switch = 1'b0;
    repeat (5) @(negedge clock);
    n_cmp++;
    if (upd_cnt != exp_upd) begin
      n_fail++; $display("FAIL abort_no_update: count %0d want %0d", upd_cnt, exp_upd);
    end
    for (int m = 0; m < N_MASTERS; m++) begin
      n_cmp++;
      if ({bus.cfg_valid[m], bus.cfg_slave[m], bus.cfg_addr[m], bus.cfg_data[m], bus.cfg_burst[m]}
          !== {m_valid[m], m_slave[m], m_addr[m], m_data[m], m_burst[m]}) begin
        n_fail++; $display("FAIL abort_desc[%0d]: got %h want %h", m, {bus.cfg_valid[m],
                           bus.cfg_slave[m], bus.cfg_addr[m], bus.cfg_data[m], bus.cfg_burst[m]},
                           {m_valid[m], m_slave[m], m_addr[m], m_data[m], m_burst[m]});
      end
    end
  endtask

  task automatic test_held_simul();
    logic [11:0] a, d, b;
    int entry;
    press(1'b1, 1'b0, 50);
    n_cmp++;
    if (bus.cfg_state !== 3'd1) begin
      n_fail++; $display("FAIL held_one_advance: state %0d want 1", bus.cfg_state);
    end
    entry = m_valid[0] ? int'(m_slave[0]) : 0;
    press(1'b1, 1'b1, 3);
    n_cmp++;
    if (bus.cfg_state !== 3'd2) begin
      n_fail++; $display("FAIL simul_next_wins: state %0d want 2", bus.cfg_state);
    end
    a = 12'($urandom); d = 12'($urandom); b = 12'($urandom);
    press(1'b1, 1'b0, 3);
    bus.switch_array = a; press(1'b1, 1'b0, 3);
    bus.switch_array = d; press(1'b1, 1'b0, 3);
    bus.switch_array = b; press(1'b1, 1'b0, 3);
    press(1'b1, 1'b0, 3);
    m_valid[0] = 1'b1; m_slave[0] = SLV_W'(entry);
    m_addr[0] = a; m_data[0] = d[7:0]; m_burst[0] = b[3:0];
    exp_upd++;
    for (int m = 0; m < N_MASTERS; m++) begin
      n_cmp++;
      if ({bus.cfg_valid[m], bus.cfg_slave[m], bus.cfg_addr[m], bus.cfg_data[m], bus.cfg_burst[m]}
          !== {m_valid[m], m_slave[m], m_addr[m], m_data[m], m_burst[m]}) begin
        n_fail++; $display("FAIL simul_desc[%0d]: got %h want %h", m, {bus.cfg_valid[m],
                           bus.cfg_slave[m], bus.cfg_addr[m], bus.cfg_data[m], bus.cfg_burst[m]},
                           {m_valid[m], m_slave[m], m_addr[m], m_data[m], m_burst[m]});
      end
    end
  endtask

  task automatic test_random();
    int ab;
    for (int it = 0; it < 20; it++) begin
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1;
      do_config(int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), 12'($urandom),
                12'($urandom), 12'($urandom), ab);
      n_cmp++;
      if (bus.cfg_state !== 3'd0 || upd_cnt != exp_upd) begin
        n_fail++; $display("FAIL rand%0d_state_upd: state %0d upd %0d want 0/%0d", it,
                           bus.cfg_state, upd_cnt, exp_upd);
      end
      for (int m = 0; m < N_MASTERS; m++) begin
        n_cmp++;
        if ({bus.cfg_valid[m], bus.cfg_slave[m], bus.cfg_addr[m], bus.cfg_data[m],
             bus.cfg_burst[m]} !== {m_valid[m], m_slave[m], m_addr[m], m_data[m], m_burst[m]}) begin
          n_fail++; $display("FAIL rand%0d_desc[%0d]: got %h want %h", it, m, {bus.cfg_valid[m],
                             bus.cfg_slave[m], bus.cfg_addr[m], bus.cfg_data[m], bus.cfg_burst[m]},
                             {m_valid[m], m_slave[m], m_addr[m], m_data[m], m_burst[m]});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    repeat (3) press(1'b1, 1'b0, 3);
    bus.switch_array = 12'h123; press(1'b1, 1'b0, 3);
    press(1'b1, 1'b0, 3);
    n_cmp++;
    if (bus.cfg_state !== 3'd5) begin
      n_fail++; $display("FAIL rstmid_bsel: state %0d want 5", bus.cfg_state);
    end
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({bus.cfg_state, bus.cfg_valid, bus.cfg_update} !== '0) begin
      n_fail++; $display("FAIL rstmid_flags: state %0d valid %b update %b want 0",
                         bus.cfg_state, bus.cfg_valid, bus.cfg_update);
    end
    for (int m = 0; m < N_MASTERS; m++) begin
      n_cmp++;
      if ({bus.cfg_slave[m], bus.cfg_addr[m], bus.cfg_data[m], bus.cfg_burst[m]} !== '0) begin
        n_fail++; $display("FAIL rstmid_desc[%0d]: got %h want 0", m,
                           {bus.cfg_slave[m], bus.cfg_addr[m], bus.cfg_data[m], bus.cfg_burst[m]});
      end
    end
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    // Slot 0 is invalid again, so the slave selector must start from 0.
    do_config(0, 2, 12'hABC, 12'h0DE, 12'h009, -1);
    n_cmp++;
    if ({bus.cfg_valid[0], bus.cfg_slave[0], bus.cfg_addr[0], bus.cfg_data[0], bus.cfg_burst[0]}
        !== {1'b1, 2'd2, 12'hABC, 8'hDE, 4'h9}) begin
      n_fail++; $display("FAIL rstmid_fresh: got %h want %h", {bus.cfg_valid[0],
                         bus.cfg_slave[0], bus.cfg_addr[0], bus.cfg_data[0], bus.cfg_burst[0]},
                         {1'b1, 2'd2, 12'hABC, 8'hDE, 4'h9});
    end
  endtask

  initial begin
    bus.mode_switch  = 1'b0;
    bus.btn_next_n   = 1'b1;
    bus.btn_inc_n    = 1'b1;
    bus.switch_array = '0;
    model_reset();
    test_reset();
    test_single();
    test_burst();
    test_wrap();
    test_abort();
    test_held_simul();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
